// File: rtl/udp_tx_sched_pkg.sv
// Shared types and constants for the UDP transmit scheduler.
// Optional sample-frame header: define UDP_TX_SCHED_HDR_EN.
package udp_sched_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_SEND  = 2'd2,
    ST_GAP   = 2'd3
  } sched_state_e;

  typedef enum logic {
    SRC_SAMPLE = 1'b0,
    SRC_REPORT = 1'b1
  } sched_src_e;

  localparam logic [7:0]  RPT_MAGIC0 = 8'hA5;
  localparam logic [7:0]  RPT_MAGIC1 = 8'h5A;
  localparam logic [7:0]  HDR_MAGIC0 = 8'h5A;
  localparam logic [7:0]  HDR_MAGIC1 = 8'hA5;
  localparam logic [15:0] RPT_LEN    = 16'd6;
  localparam logic [15:0] HDR_LEN    = 16'd4;

  // Byte at position idx of a frequency-report frame.
  function automatic logic [7:0] report_byte(input logic [15:0] idx, input logic [31:0] freq);
    logic [7:0] b;
    case (idx)
      16'd0:   b = RPT_MAGIC0;
      16'd1:   b = RPT_MAGIC1;
      16'd2:   b = freq[31:24];
      16'd3:   b = freq[23:16];
      16'd4:   b = freq[15:8];
      16'd5:   b = freq[7:0];
      default: b = '0;
    endcase
    return b;
  endfunction

  // Byte at position idx of the sample-frame header.
  function automatic logic [7:0] header_byte(input logic [15:0] idx, input logic [15:0] seq);
    logic [7:0] b;
    case (idx)
      16'd0:   b = HDR_MAGIC0;
      16'd1:   b = HDR_MAGIC1;
      16'd2:   b = seq[15:8];
      16'd3:   b = seq[7:0];
      default: b = '0;
    endcase
    return b;
  endfunction

endpackage

// File: rtl/udp_tx_sched_frame_timer.sv
// Shared down-counter used for both the inter-frame gap and the frame timeout.
module udp_frame_timer #(
  parameter int unsigned W = 18
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         expired_o
);

  logic [W-1:0] cnt_q;

  // Load on request, otherwise count down and park at zero.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (cnt_q != '0) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/udp_tx_sched.sv
// Transmit scheduler: arbitrates FIFO sample frames and frequency-report
// frames onto the UDP engine with inter-frame gap and timeout recovery.
// Optional sample header (sequence number): define UDP_TX_SCHED_HDR_EN.
module udp_tx_sched
  import udp_sched_pkg::*;
#(
  parameter int unsigned SAMPLE_LEN     = 1024,
  parameter int unsigned GAP_CYCLES     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 200000
) (
  input  logic        clk_125m,
  input  logic        rst,
  input  logic [12:0] fifo_rd_count,
  output logic        fifo_rd_en,
  input  logic [7:0]  fifo_dout,
  input  logic [31:0] wave_freq,
  input  logic        freq_valid,
  output logic        tx_start_en,
  output logic [15:0] tx_byte_num,
  output logic [7:0]  tx_data,
  input  logic        tx_req,
  input  logic        tx_done,
  output logic        busy,
  output logic        err_timeout
);

`ifdef UDP_TX_SCHED_HDR_EN
  localparam logic [15:0] SMP_HDR = HDR_LEN;
`else
  localparam logic [15:0] SMP_HDR = '0;
`endif
  localparam logic [15:0]  SMP_TOTAL = 16'(SAMPLE_LEN) + SMP_HDR;
  localparam int unsigned  TMR_MAX   = (TIMEOUT_CYCLES > GAP_CYCLES) ? TIMEOUT_CYCLES : GAP_CYCLES;
  localparam int unsigned  TMR_W     = $clog2(TMR_MAX + 1);

  sched_state_e state_q, state_d;
  sched_src_e   src_q, src_d;
  sched_src_e   last_src_q, last_src_d;
  logic         rpt_pend_q, rpt_pend_d;
  logic [31:0]  rpt_freq_q, rpt_freq_d;
  logic [31:0]  frame_freq_q, frame_freq_d;
  logic [15:0]  byte_num_q, byte_num_d;
  logic [15:0]  idx_q, idx_d;
  logic [7:0]   data_q, data_d;
  logic         rd_pend_q, rd_pend_d;
  logic         err_q, err_d;
`ifdef UDP_TX_SCHED_HDR_EN
  logic [15:0]  seq_q, seq_d;
`endif

  logic             smp_ok;
  logic             req_ok;
  logic             fifo_byte;
  logic             tmr_load;
  logic [TMR_W-1:0] tmr_val;
  logic             tmr_expired;
  sched_src_e       sel;

  udp_frame_timer #(.W(TMR_W)) u_timer (
    .clk_i      (clk_125m),
    .rst_i      (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_val),
    .expired_o  (tmr_expired)
  );

  assign smp_ok = ({3'b000, fifo_rd_count} >= 16'(SAMPLE_LEN));
  assign req_ok = (state_q == ST_SEND) && tx_req && (idx_q < byte_num_q);
`ifdef UDP_TX_SCHED_HDR_EN
  assign fifo_byte = (src_q == SRC_SAMPLE) && (idx_q >= SMP_HDR);
`else
  assign fifo_byte = (src_q == SRC_SAMPLE);
`endif

  assign fifo_rd_en  = req_ok && fifo_byte;
  assign tx_start_en = (state_q == ST_START);
  assign busy        = (state_q != ST_IDLE);
  assign tx_byte_num = byte_num_q;
  assign err_timeout = err_q;
  // FIFO bytes arrive one cycle after the strobe; generated bytes are registered to line up.
  assign tx_data     = rd_pend_q ? fifo_dout : data_q;

  // Next-state logic: arbitration, byte sequencing, gap and timeout handling.
  always_comb begin
    state_d      = state_q;
    src_d        = src_q;
    last_src_d   = last_src_q;
    rpt_pend_d   = rpt_pend_q;
    rpt_freq_d   = rpt_freq_q;
    frame_freq_d = frame_freq_q;
    byte_num_d   = byte_num_q;
    idx_d        = idx_q;
    data_d       = '0;
    rd_pend_d    = fifo_rd_en;
    err_d        = err_q;
`ifdef UDP_TX_SCHED_HDR_EN
    seq_d        = seq_q;
`endif
    tmr_load     = 1'b0;
    tmr_val      = '0;
    sel          = SRC_SAMPLE;

    if (freq_valid) begin
      rpt_freq_d = wave_freq;
      rpt_pend_d = 1'b1;
    end

    case (state_q)
      ST_IDLE: begin
        if (rpt_pend_q || smp_ok) begin
          sel        = (rpt_pend_q && !(smp_ok && last_src_q == SRC_REPORT)) ? SRC_REPORT : SRC_SAMPLE;
          src_d      = sel;
          last_src_d = sel;
          idx_d      = '0;
          state_d    = ST_START;
          tmr_load   = 1'b1;
          tmr_val    = TMR_W'(TIMEOUT_CYCLES - 1);
          if (sel == SRC_REPORT) begin
            byte_num_d   = RPT_LEN;
            // Snapshot the report so a strobe arriving now stays pending for the next frame.
            frame_freq_d = rpt_freq_q;
            if (!freq_valid) rpt_pend_d = 1'b0;
          end else begin
            byte_num_d = SMP_TOTAL;
          end
        end
      end
      ST_START: begin
        state_d = ST_SEND;
      end
      ST_SEND: begin
        if (req_ok) begin
          idx_d = idx_q + 16'd1;
          if (!fifo_byte) begin
`ifdef UDP_TX_SCHED_HDR_EN
            data_d = (src_q == SRC_REPORT) ? report_byte(idx_q, frame_freq_q) : header_byte(idx_q, seq_q);
`else
            data_d = report_byte(idx_q, frame_freq_q);
`endif
          end
        end
        if (tx_done) begin
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(GAP_CYCLES - 1);
`ifdef UDP_TX_SCHED_HDR_EN
          if (src_q == SRC_SAMPLE) seq_d = seq_q + 16'd1;
`endif
        end else if (tmr_expired) begin
          err_d    = 1'b1;
          state_d  = ST_GAP;
          tmr_load = 1'b1;
          tmr_val  = TMR_W'(GAP_CYCLES - 1);
        end
      end
      ST_GAP: begin
        if (tmr_expired) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State registers with synchronous reset.
  always_ff @(posedge clk_125m) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      src_q        <= SRC_SAMPLE;
      last_src_q   <= SRC_SAMPLE;
      rpt_pend_q   <= 1'b0;
      rpt_freq_q   <= '0;
      frame_freq_q <= '0;
      byte_num_q   <= '0;
      idx_q        <= '0;
      data_q       <= '0;
      rd_pend_q    <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      src_q        <= src_d;
      last_src_q   <= last_src_d;
      rpt_pend_q   <= rpt_pend_d;
      rpt_freq_q   <= rpt_freq_d;
      frame_freq_q <= frame_freq_d;
      byte_num_q   <= byte_num_d;
      idx_q        <= idx_d;
      data_q       <= data_d;
      rd_pend_q    <= rd_pend_d;
      err_q        <= err_d;
    end
  end

`ifdef UDP_TX_SCHED_HDR_EN
  // Sample-frame sequence number.
  always_ff @(posedge clk_125m) begin
    if (rst) seq_q <= '0;
    else     seq_q <= seq_d;
  end
`endif

endmodule

// File: tb/tb_udp_tx_sched.sv
// Directed self-checking bench for udp_tx_sched (timeout shortened for run time).
module tb_udp_tx_sched;

  localparam int SLEN = 1024;
  localparam int GAP  = 64;
  localparam int TMO  = 3000;
`ifdef UDP_TX_SCHED_HDR_EN
  localparam int HDR  = 4;
`else
  localparam int HDR  = 0;
`endif
  localparam int SMP_BYTES = SLEN + HDR;

  logic        clk = 1'b0;
  logic        rst;
  logic [12:0] fifo_rd_count;
  logic        fifo_rd_en;
  logic [7:0]  fifo_dout;
  logic [31:0] wave_freq;
  logic        freq_valid;
  logic        tx_start_en;
  logic [15:0] tx_byte_num;
  logic [7:0]  tx_data;
  logic        tx_req;
  logic        tx_done;
  logic        busy;
  logic        err_timeout;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rd_ptr  = 0;
  int rd_seen;
  int base_ptr;
  int exp_seq = 0;
  logic [7:0] rx [0:2047];

  udp_tx_sched #(
    .SAMPLE_LEN     (SLEN),
    .GAP_CYCLES     (GAP),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .clk_125m      (clk),
    .rst           (rst),
    .fifo_rd_count (fifo_rd_count),
    .fifo_rd_en    (fifo_rd_en),
    .fifo_dout     (fifo_dout),
    .wave_freq     (wave_freq),
    .freq_valid    (freq_valid),
    .tx_start_en   (tx_start_en),
    .tx_byte_num   (tx_byte_num),
    .tx_data       (tx_data),
    .tx_req        (tx_req),
    .tx_done       (tx_done),
    .busy          (busy),
    .err_timeout   (err_timeout)
  );

  always #4 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [7:0] pat(input int p);
    logic [31:0] v;
    v = p;
    return v[7:0] ^ 8'h3C;
  endfunction

  // FIFO read port: one-cycle read latency, data pattern keyed by read pointer.
  always @(posedge clk) begin
    if (fifo_rd_en) begin
      fifo_dout <= pat(rd_ptr);
      rd_ptr    <= rd_ptr + 1;
    end
  end

  function automatic logic [7:0] exp_smp(input int i, input logic [15:0] seq, input int base);
    if (i < HDR) begin
      case (i)
        0:       return 8'h5A;
        1:       return 8'hA5;
        2:       return seq[15:8];
        default: return seq[7:0];
      endcase
    end
    return pat(base + i - HDR);
  endfunction

  function automatic int count_smp_errs(input logic [15:0] seq, input int base);
    int e;
    e = 0;
    for (int i = 0; i < SMP_BYTES; i++)
      if (rx[i] !== exp_smp(i, seq, base)) e++;
    return e;
  endfunction

  task automatic wait_start(input int budget, output bit seen, output int n);
    seen = 1'b0;
    n    = 0;
    while (!seen && n < budget) begin
      @(negedge clk);
      n++;
      freq_valid = 1'b0;
      if (tx_start_en) seen = 1'b1;
    end
  endtask

  // Engine model: issue nreq byte requests back to back, capture tx_data, optionally pulse tx_done.
  task automatic drive_frame(input int nreq, input bit do_done);
    rd_seen  = 0;
    base_ptr = rd_ptr;
    for (int i = 0; i < nreq; i++) begin
      @(negedge clk);
      if (i > 0) rx[i-1] = tx_data;
      tx_req = 1'b1;
      #1;
      if (fifo_rd_en) rd_seen++;
    end
    @(negedge clk);
    if (nreq > 0) rx[nreq-1] = tx_data;
    tx_req = 1'b0;
    if (do_done) begin
      tx_done = 1'b1;
      @(negedge clk);
      tx_done = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; fifo_rd_count = '0; wave_freq = '0; freq_valid = 1'b0;
    tx_req = 1'b0; tx_done = 1'b0; fifo_dout = 8'h77;
    repeat (3) @(negedge clk);
    n_tests++; if (tx_start_en !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %0h expected 0", tx_start_en); end
    n_tests++; if (fifo_rd_en !== 1'b0) begin n_fail++; $display("FAIL reset_rd_en: got %0h expected 0", fifo_rd_en); end
    n_tests++; if (tx_byte_num !== 16'h0) begin n_fail++; $display("FAIL reset_byte_num: got %0h expected 0", tx_byte_num); end
    n_tests++; if (tx_data !== 8'h0) begin n_fail++; $display("FAIL reset_data: got %0h expected 0", tx_data); end
    n_tests++; if ({busy, err_timeout} !== 2'b00) begin n_fail++; $display("FAIL reset_busy_err: got %b expected 00", {busy, err_timeout}); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_sample();
    bit seen; int n; int errs;
    fifo_rd_count = 13'd1024;
    wait_start(10, seen, n);
    fifo_rd_count = '0;
    n_tests++; if (!seen || n !== 1) begin n_fail++; $display("FAIL sample_latency: got %0d cycles (seen=%0d) expected 1", n, seen); end
    n_tests++; if (tx_byte_num !== 16'(SMP_BYTES)) begin n_fail++; $display("FAIL sample_byte_num: got %0d expected %0d", tx_byte_num, SMP_BYTES); end
    drive_frame(SMP_BYTES + 2, 1'b1);
    n_tests++; if (rd_seen !== SLEN) begin n_fail++; $display("FAIL sample_reads: got %0d expected %0d", rd_seen, SLEN); end
    errs = count_smp_errs(16'(exp_seq), base_ptr);
    n_tests++; if (errs !== 0) begin n_fail++; $display("FAIL sample_payload: got %0d bad bytes expected 0", errs); end
    n_tests++; if ({rx[SMP_BYTES], rx[SMP_BYTES+1]} !== 16'h0000) begin n_fail++; $display("FAIL sample_overrun: got %h expected 0000", {rx[SMP_BYTES], rx[SMP_BYTES+1]}); end
    exp_seq++;
  endtask

  task automatic test_report();
    bit seen; int n; logic [7:0] exp_r [0:7];
    exp_r[0] = 8'hA5; exp_r[1] = 8'h5A; exp_r[2] = 8'h00; exp_r[3] = 8'h01;
    exp_r[4] = 8'h23; exp_r[5] = 8'h45; exp_r[6] = 8'h00; exp_r[7] = 8'h00;
    wait_start(200, seen, n);   // drains the previous gap; no start expected here
    n_tests++; if (seen) begin n_fail++; $display("FAIL idle_spurious_start: got start after %0d cycles expected none", n); end
    wave_freq = 32'h0001_2345; freq_valid = 1'b1;
    wait_start(10, seen, n);
    n_tests++; if (!seen || n !== 2) begin n_fail++; $display("FAIL report_latency: got %0d cycles (seen=%0d) expected 2", n, seen); end
    n_tests++; if (tx_byte_num !== 16'd6) begin n_fail++; $display("FAIL report_byte_num: got %0d expected 6", tx_byte_num); end
    drive_frame(8, 1'b1);
    for (int i = 0; i < 8; i++) begin
      n_tests++; if (rx[i] !== exp_r[i]) begin n_fail++; $display("FAIL report_byte%0d: got %h expected %h", i, rx[i], exp_r[i]); end
    end
    n_tests++; if (rd_seen !== 0) begin n_fail++; $display("FAIL report_reads: got %0d expected 0", rd_seen); end
  endtask

  task automatic test_alternation();
    bit seen; int n; int errs; logic [31:0] got;
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL gap_busy: got %0h expected 1", busy); end
    wave_freq = 32'hDEAD_BEEF; freq_valid = 1'b1; fifo_rd_count = 13'd1024;
    wait_start(200, seen, n);
    fifo_rd_count = '0;
    n_tests++; if (!seen || n !== GAP + 1) begin n_fail++; $display("FAIL alt_gap: got %0d cycles (seen=%0d) expected %0d", n, seen, GAP + 1); end
    n_tests++; if (tx_byte_num !== 16'(SMP_BYTES)) begin n_fail++; $display("FAIL alt_sample_first: got %0d expected %0d", tx_byte_num, SMP_BYTES); end
    drive_frame(SMP_BYTES, 1'b1);
    errs = count_smp_errs(16'(exp_seq), base_ptr);
    n_tests++; if (errs !== 0 || rd_seen !== SLEN) begin n_fail++; $display("FAIL alt_sample_payload: got %0d bad bytes, %0d reads expected 0, %0d", errs, rd_seen, SLEN); end
    exp_seq++;
    wait_start(200, seen, n);
    n_tests++; if (!seen || n !== GAP + 1 || tx_byte_num !== 16'd6) begin n_fail++; $display("FAIL alt_report_next: got %0d cycles len %0d expected %0d cycles len 6", n, tx_byte_num, GAP + 1); end
    drive_frame(6, 1'b1);
    got = {rx[2], rx[3], rx[4], rx[5]};
    n_tests++; if (got !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL alt_report_freq: got %h expected deadbeef", got); end
  endtask

  task automatic test_timeout();
    bit seen; int n; int start_cyc; int errs;
    fifo_rd_count = 13'd1024;
    wait_start(200, seen, n);
    fifo_rd_count = '0;
    start_cyc = cyc;
    drive_frame(10, 1'b0);
    while (cyc - start_cyc < TMO - 1) @(negedge clk);
    n_tests++; if ({err_timeout, busy} !== 2'b01) begin n_fail++; $display("FAIL timeout_early: got err/busy %b expected 01", {err_timeout, busy}); end
    @(negedge clk);
    n_tests++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_rise: got %0h expected 1", err_timeout); end
    fifo_rd_count = 13'd1024;
    wait_start(200, seen, n);
    fifo_rd_count = '0;
    n_tests++; if (!seen || n !== GAP + 1) begin n_fail++; $display("FAIL timeout_restart: got %0d cycles (seen=%0d) expected %0d", n, seen, GAP + 1); end
    drive_frame(SMP_BYTES, 1'b1);
    errs = count_smp_errs(16'(exp_seq), base_ptr);
    n_tests++; if (errs !== 0 || rd_seen !== SLEN) begin n_fail++; $display("FAIL timeout_next_frame: got %0d bad bytes, %0d reads expected 0, %0d", errs, rd_seen, SLEN); end
    exp_seq++;
    n_tests++; if (err_timeout !== 1'b1) begin n_fail++; $display("FAIL timeout_sticky: got %0h expected 1", err_timeout); end
  endtask

  task automatic test_reset_mid();
    bit seen; int n; int errs;
    fifo_rd_count = 13'd1024;
    wait_start(200, seen, n);
    fifo_rd_count = '0;
    @(negedge clk);
    tx_req = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    #1;
    n_tests++; if ({tx_start_en, fifo_rd_en, busy, err_timeout} !== 4'b0000) begin n_fail++; $display("FAIL midrst_flags: got %b expected 0000", {tx_start_en, fifo_rd_en, busy, err_timeout}); end
    n_tests++; if ({tx_byte_num, tx_data} !== 24'h0) begin n_fail++; $display("FAIL midrst_values: got %h expected 000000", {tx_byte_num, tx_data}); end
    tx_req = 1'b0; rst = 1'b0; exp_seq = 0;
    @(negedge clk);
    fifo_rd_count = 13'd1024;
    wait_start(10, seen, n);
    fifo_rd_count = '0;
    n_tests++; if (!seen || n !== 1 || tx_byte_num !== 16'(SMP_BYTES)) begin n_fail++; $display("FAIL midrst_restart: got %0d cycles len %0d expected 1 cycle len %0d", n, tx_byte_num, SMP_BYTES); end
    drive_frame(SMP_BYTES, 1'b1);
    errs = count_smp_errs(16'(exp_seq), base_ptr);
    n_tests++; if (errs !== 0 || rd_seen !== SLEN) begin n_fail++; $display("FAIL midrst_frame: got %0d bad bytes, %0d reads expected 0, %0d", errs, rd_seen, SLEN); end
    exp_seq++;
  endtask

  initial begin
    test_reset();
    test_sample();
    test_report();
    test_alternation();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #(8 * 60000);
    $display("FAIL watchdog: got no completion expected finish within 60000 cycles");
    $fatal(1, "watchdog expired");
  end

endmodule
